// File: rtl/video_scroll_engine_if.sv
// CPU-side and video-side register bus seen by the scroll engine.
// master = CPU and video block side, slave = engine.
interface video_scroll_engine_if;
    logic       R_W_n;
    logic [7:0] reg_addr_i;
    logic [7:0] data_i;
    logic       video_cs;
    logic       eng_cs;
    logic [7:0] data_o;
    logic [7:0] vid_addr_o;
    logic [7:0] vid_data_o;
    logic       vid_rw_n_o;
    logic       vid_cs_o;
    logic [7:0] vid_data_i;
    logic       busy_o;

    modport master (
        output R_W_n, reg_addr_i, data_i, video_cs, eng_cs, vid_data_i,
        input  data_o, vid_addr_o, vid_data_o, vid_rw_n_o, vid_cs_o, busy_o
    );

    modport slave (
        input  R_W_n, reg_addr_i, data_i, video_cs, eng_cs, vid_data_i,
        output data_o, vid_addr_o, vid_data_o, vid_rw_n_o, vid_cs_o, busy_o
    );
endinterface

// File: rtl/video_scroll_engine.sv
// Hardware scroll-up / clear-screen / clear-line engine in front of the text video port.
// Latency: pass-through is combinational; an operation owns the video port while busy_o, no backpressure.
module video_scroll_engine #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    video_scroll_engine_if.slave bus
);

    localparam logic [1:0] OP_SCROLL = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_LINE   = 2'd3;
    localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
    localparam logic [4:0] ROW_PEN   = 5'(ROWS - 2);

    typedef enum logic [2:0] {IDLE, SAVE, SEL_SRC, READ, SEL_DST, WRITE, RESTORE} state_t;

    state_t     state, state_nxt;
    logic [1:0] op, op_nxt;
    logic [4:0] row, row_nxt, row_inc;
    logic [6:0] col, col_nxt;
    logic [7:0] fill;
    logic [4:0] target;
    logic [4:0] saved_line;
    logic [7:0] line_buf [COLS];

    logic       busy, eng_wr, cmd_ok, copy_mode, col_last;
    logic [7:0] col_addr, eng_addr, eng_dat, rd_dat;
    logic       eng_rw_n;

    assign busy      = (state != IDLE);
    assign eng_wr    = bus.eng_cs & ~bus.R_W_n;
    assign row_inc   = row + 5'd1;
    assign col_last  = (col == COL_LAST);
    assign col_addr  = 8'h80 + {1'b0, col};
    assign copy_mode = (op == OP_SCROLL) && (row != ROW_LAST);
    assign cmd_ok    = ~busy & eng_wr & (bus.reg_addr_i[1:0] == 2'd0) &
                       ((bus.data_i == 8'd1) | (bus.data_i == 8'd2) |
                        ((bus.data_i == 8'd3) & ({3'b000, target} < 8'(ROWS))));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        row_nxt   = row;
        col_nxt   = col;
        eng_addr  = 8'h00;
        eng_dat   = 8'h00;
        eng_rw_n  = 1'b1;
        case (state)
            IDLE: begin
                if (cmd_ok) begin
                    state_nxt = SAVE;
                    op_nxt    = bus.data_i[1:0];
                    row_nxt   = (bus.data_i[1:0] == OP_LINE) ? target : 5'd0;
                    col_nxt   = 7'd0;
                end
            end
            SAVE: state_nxt = (op == OP_SCROLL) ? SEL_SRC : SEL_DST;
            SEL_SRC: begin
                eng_rw_n  = 1'b0;
                eng_dat   = {3'b000, row_inc};
                col_nxt   = 7'd0;
                state_nxt = READ;
            end
            READ: begin
                eng_addr = col_addr;
                if (col_last) begin
                    col_nxt   = 7'd0;
                    state_nxt = SEL_DST;
                end else begin
                    col_nxt = col + 7'd1;
                end
            end
            SEL_DST: begin
                eng_rw_n  = 1'b0;
                eng_dat   = {3'b000, row};
                col_nxt   = 7'd0;
                state_nxt = WRITE;
            end
            WRITE: begin
                eng_rw_n = 1'b0;
                eng_addr = col_addr;
                eng_dat  = copy_mode ? line_buf[col] : fill;
                if (col_last) begin
                    col_nxt = 7'd0;
                    // Scroll copies rows 0..ROWS-2, then fills the last row once.
                    if (copy_mode) begin
                        row_nxt   = row_inc;
                        state_nxt = (row == ROW_PEN) ? SEL_DST : SEL_SRC;
                    end else if ((op == OP_CLEAR) && (row != ROW_LAST)) begin
                        row_nxt   = row_inc;
                        state_nxt = SEL_DST;
                    end else begin
                        state_nxt = RESTORE;
                    end
                end else begin
                    col_nxt = col + 7'd1;
                end
            end
            RESTORE: begin
                eng_rw_n  = 1'b0;
                eng_dat   = {3'b000, saved_line};
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op         <= 2'd0;
            row        <= 5'd0;
            col        <= 7'd0;
            fill       <= 8'h20;
            target     <= 5'd0;
            saved_line <= 5'd0;
        end else begin
            op  <= op_nxt;
            row <= row_nxt;
            col <= col_nxt;
            if (state == SAVE)
                saved_line <= bus.vid_data_i[4:0];
            if (~busy && eng_wr && (bus.reg_addr_i[1:0] == 2'd1))
                fill <= bus.data_i;
            if (~busy && eng_wr && (bus.reg_addr_i[1:0] == 2'd2))
                target <= bus.data_i[4:0];
        end
    end

    // Line buffer holds no state worth resetting; it is always refilled before use.
    always_ff @(posedge clk_i) begin
        if (state == READ)
            line_buf[col] <= bus.vid_data_i;
    end

    always_comb begin
        rd_dat = 8'h00;
        if (bus.video_cs) begin
            rd_dat = busy ? 8'h00 : bus.vid_data_i;
        end else begin
            case (bus.reg_addr_i[1:0])
                2'd1:    rd_dat = fill;
                2'd2:    rd_dat = {3'b000, target};
                2'd3:    rd_dat = {7'b0000000, busy};
                default: rd_dat = 8'h00;
            endcase
        end
    end

    assign bus.data_o     = rd_dat;
    assign bus.vid_addr_o = busy ? eng_addr : bus.reg_addr_i;
    assign bus.vid_data_o = busy ? eng_dat  : bus.data_i;
    assign bus.vid_rw_n_o = busy ? eng_rw_n : bus.R_W_n;
    assign bus.vid_cs_o   = busy | bus.video_cs;
    assign bus.busy_o     = busy;

endmodule

// File: tb/tb_video_scroll_engine.sv
// Bench for video_scroll_engine with a behavioural text-mode video block attached.
module tb_video_scroll_engine;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_scroll_engine_if vb();

    video_scroll_engine #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (vb)
    );

    // Video block model: line select at 0x00, row data at 0x80..0xCF, read data combinational.
    logic [7:0] vmem [ROWS][COLS] = '{default: 8'h00};
    logic [7:0] vline = 8'h00;

    always @(posedge clk) begin
        if (vb.vid_cs_o && !vb.vid_rw_n_o) begin
            if (vb.vid_addr_o == 8'h00)
                vline <= vb.vid_data_o;
            else if (vb.vid_addr_o[7] && (vb.vid_addr_o[6:0] < 7'(COLS)) && (vline < 8'(ROWS)))
                vmem[vline[4:0]][vb.vid_addr_o[6:0]] <= vb.vid_data_o;
        end
    end

    always_comb begin
        vb.vid_data_i = 8'h00;
        if (vb.vid_addr_o == 8'h00)
            vb.vid_data_i = vline;
        else if (vb.vid_addr_o[7] && (vb.vid_addr_o[6:0] < 7'(COLS)) && (vline < 8'(ROWS)))
            vb.vid_data_i = vmem[vline[4:0]][vb.vid_addr_o[6:0]];
    end

    // Cycle counter and busy edge / video access monitor.
    int   cyc = 0, t_rise = 0, t_fall = 0, n_rise = 0, vacc = 0;
    logic busy_q = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (vb.vid_cs_o === 1'b1) vacc = vacc + 1;
        if ((vb.busy_o === 1'b1) && !busy_q) begin
            t_rise = cyc;
            n_rise = n_rise + 1;
        end
        if ((vb.busy_o === 1'b0) && busy_q) t_fall = cyc;
        busy_q = (vb.busy_o === 1'b1);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_row(input int r, input logic [7:0] base, input bit ramp);
        logic [7:0] e;
        int bad = -1;
        for (int c = 0; c < COLS; c++) begin
            e = ramp ? 8'(base + 8'(c)) : base;
            if ((vmem[r][c] !== e) && (bad < 0)) bad = c;
        end
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            e = ramp ? 8'(base + 8'(bad)) : base;
            $display("FAIL row%0d col%0d: got %02h expected %02h", r, bad, vmem[r][bad], e);
        end
    endtask

    task automatic bus_idle();
        vb.video_cs   = 1'b0;
        vb.eng_cs     = 1'b0;
        vb.R_W_n      = 1'b1;
        vb.reg_addr_i = 8'h00;
        vb.data_i     = 8'h00;
    endtask

    task automatic cpu_wr(input bit vid, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        vb.video_cs   = vid;
        vb.eng_cs     = !vid;
        vb.R_W_n      = 1'b0;
        vb.reg_addr_i = a;
        vb.data_i     = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic cpu_rd(input bit vid, input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        vb.video_cs   = vid;
        vb.eng_cs     = !vid;
        vb.R_W_n      = 1'b1;
        vb.reg_addr_i = a;
        #1 d = vb.data_o;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((vb.busy_o !== 1'b0) && (n < 6000)) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, 32'(vb.busy_o), 32'd0);
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input int exp_dur, input string nm);
        cpu_wr(1'b0, 8'h00, cmd);
        chk({nm, "_busy_rise"}, 32'(vb.busy_o), 32'd1);
        wait_idle(nm);
        chk({nm, "_duration"}, 32'(t_fall - t_rise), 32'(exp_dur));
    endtask

    typedef struct {
        bit         vid;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [17];
    logic [7:0] d;
    int         r0, v0;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h20};
        vecs[1]  = '{1'b0, 1'b0, 8'h02, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h03, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 8'h01, 8'h5A, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h5A};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 8'h02, 8'hFF, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 8'h02, 8'h00, 8'h1F};
        vecs[9]  = '{1'b1, 1'b1, 8'h00, 8'h03, 8'h00};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h03};
        vecs[11] = '{1'b1, 1'b1, 8'h85, 8'h77, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 8'h85, 8'h00, 8'h77};
        vecs[13] = '{1'b1, 1'b0, 8'h86, 8'h00, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 8'h01, 8'h20, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h20};

        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(vb.busy_o), 32'd0);
        chk("reset_vid_cs", 32'(vb.vid_cs_o), 32'd0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                cpu_wr(vecs[i].vid, vecs[i].addr, vecs[i].wdat);
            end else begin
                cpu_rd(vecs[i].vid, vecs[i].addr, d);
                chk($sformatf("vec%0d", i), 32'(d), 32'(vecs[i].exp));
            end
        end

        // Scroll up over a ramp pattern.
        for (int r = 0; r < ROWS; r++) begin
            cpu_wr(1'b1, 8'h00, 8'(r));
            for (int c = 0; c < COLS; c++)
                cpu_wr(1'b1, 8'(8'h80 + c), 8'(r * 2 + c));
        end
        cpu_wr(1'b1, 8'h00, 8'd7);
        check_row(3, 8'd6, 1'b1);
        run_cmd(8'd1, 4781, "scroll");
        for (int r = 0; r < ROWS - 1; r++)
            check_row(r, 8'((r + 1) * 2), 1'b1);
        check_row(ROWS - 1, 8'h20, 1'b0);
        cpu_rd(1'b1, 8'h00, d);
        chk("scroll_line_restore", 32'(d), 32'd7);

        // Clear screen.
        cpu_wr(1'b0, 8'h01, 8'h41);
        cpu_wr(1'b1, 8'h00, 8'd12);
        run_cmd(8'd2, 2432, "clear");
        for (int r = 0; r < ROWS; r++)
            check_row(r, 8'h41, 1'b0);
        cpu_rd(1'b1, 8'h00, d);
        chk("clear_line_restore", 32'(d), 32'd12);

        // Clear line 5, then an out-of-range target.
        cpu_wr(1'b0, 8'h02, 8'd5);
        cpu_wr(1'b0, 8'h01, 8'h2A);
        run_cmd(8'd3, 83, "clrline");
        for (int r = 0; r < ROWS; r++)
            check_row(r, (r == 5) ? 8'h2A : 8'h41, 1'b0);
        cpu_rd(1'b1, 8'h00, d);
        chk("clrline_line_restore", 32'(d), 32'd12);
        r0 = n_rise;
        cpu_wr(1'b0, 8'h02, 8'd30);
        cpu_wr(1'b0, 8'h00, 8'd3);
        repeat (3) @(negedge clk);
        chk("target30_no_busy", 32'(n_rise - r0), 32'd0);
        chk("target30_busy", 32'(vb.busy_o), 32'd0);

        // CPU activity during a scroll.
        r0 = n_rise;
        cpu_wr(1'b0, 8'h00, 8'd1);
        repeat (20) @(negedge clk);
        cpu_wr(1'b1, 8'h80, 8'h55);
        cpu_rd(1'b1, 8'h80, d);
        chk("busy_video_read", 32'(d), 32'd0);
        cpu_wr(1'b0, 8'h00, 8'd2);
        cpu_rd(1'b0, 8'h03, d);
        chk("busy_status", 32'(d), 32'd1);
        wait_idle("scroll2");
        chk("scroll2_duration", 32'(t_fall - t_rise), 32'd4781);
        repeat (5) @(negedge clk);
        chk("scroll2_single_op", 32'(n_rise - r0), 32'd1);
        for (int r = 0; r < ROWS; r++)
            check_row(r, ((r == 4) || (r == ROWS - 1)) ? 8'h2A : 8'h41, 1'b0);
        cpu_rd(1'b1, 8'h00, d);
        chk("scroll2_line_restore", 32'(d), 32'd12);

        // Reset in the middle of a scroll.
        cpu_wr(1'b0, 8'h00, 8'd1);
        for (int n = 0; (n < 200) && ((cyc - t_rise) < 100); n++)
            @(negedge clk);
        rst           = 1'b1;
        vb.video_cs   = 1'b1;
        vb.R_W_n      = 1'b1;
        vb.reg_addr_i = 8'h85;
        @(negedge clk);
        chk("abort_busy", 32'(vb.busy_o), 32'd0);
        chk("abort_vid_cs", 32'(vb.vid_cs_o), 32'd1);
        chk("abort_vid_addr", 32'(vb.vid_addr_o), 32'h85);
        rst = 1'b0;
        bus_idle();
        #1;
        chk("abort_vid_cs_low", 32'(vb.vid_cs_o), 32'd0);
        cpu_rd(1'b0, 8'h01, d);
        chk("abort_fill", 32'(d), 32'h20);
        cpu_rd(1'b0, 8'h02, d);
        chk("abort_target", 32'(d), 32'd0);
        run_cmd(8'd3, 83, "post_abort");
        check_row(0, 8'h20, 1'b0);
        check_row(1, 8'h41, 1'b0);

        // Invalid command codes.
        r0 = n_rise;
        v0 = vacc;
        cpu_wr(1'b0, 8'h00, 8'd0);
        cpu_wr(1'b0, 8'h00, 8'd4);
        repeat (3) @(negedge clk);
        chk("badcmd_no_busy", 32'(n_rise - r0), 32'd0);
        chk("badcmd_no_video", 32'(vacc - v0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/video_scroll_engine.md
Name: video_scroll_engine

Overview:
- Sits directly upstream of the text-mode video block, between the CPU bus and the video register port (line select at 0x00, line data at 0x80-0xCF).
- While idle, it passes CPU accesses through to the video block unchanged.
- On command, it takes over the video port and runs hardware scroll-up, clear-screen or clear-line operations on the 80x30 character buffer, using an internal 80-byte line buffer.
- Afterwards it restores the CPU's line-select value, so software sees no side effect except the buffer contents.

Parameters:
- COLS, 80, characters per row; data offsets 0x80..0x80+COLS-1.
- ROWS, 30, text rows; valid line-select values 0..ROWS-1.

Ports:
- clk_i  in  1  system clock; same clock as the video block.
- rst_i  in  1  synchronous active-high reset.
- R_W_n  in  1  CPU read/write_n.
- reg_addr_i  in  8  CPU register address.
- data_i  in  8  CPU write data.
- video_cs  in  1  CPU select of the video register window.
- eng_cs  in  1  CPU select of engine registers; uses reg_addr_i[1:0].
- data_o  out  8  CPU read data, from video or engine.
- vid_addr_o  out  8  video reg_addr_i.
- vid_data_o  out  8  video data_i.
- vid_rw_n_o  out  1  video R_W_n.
- vid_cs_o  out  1  video video_cs.
- vid_data_i  in  8  video data_o.
- busy_o  out  1  operation in progress.

Behaviour:
- Engine registers, selected by reg_addr_i[1:0] when eng_cs=1:
  - 0 CMD (write-only): 1 = scroll up, 2 = clear screen, 3 = clear line.
  - 1 FILL: fill character, reset value 0x20.
  - 2 TARGET: row for clear-line, 5 bits, reset value 0.
  - 3 STATUS: bit0 = busy, other bits 0.
  - Reads of CMD return 0. FILL and TARGET read back.
- Register writes take effect on the rising edge with eng_cs & ~R_W_n.
- CMD is ignored when busy, when the value is not 1-3, or for clear-line with TARGET >= ROWS.
- Idle pass-through: vid_* = CPU signals, combinational. data_o = vid_data_i when video_cs, else the engine register value.
- Busy: CPU video writes are dropped and video reads return 0x00. Engine registers stay accessible, but FILL and TARGET writes are ignored.
- Read timing: a video read is valid at the rising edge that ends the cycle in which the address is driven, and the engine samples it there.
- FSM states: IDLE, SAVE, SEL_SRC, READ, SEL_DST, WRITE, RESTORE.
  - SAVE: read addr 0x00, latch saved_line[4:0]. 1 cycle.
  - SEL_SRC: write src row to 0x00. 1 cycle.
  - READ: addresses 0x80+c for c=0..COLS-1; byte c goes to buf[c]. COLS cycles.
  - SEL_DST: write dst row to 0x00. 1 cycle.
  - WRITE: write buf[c] (copy) or FILL (clear) to 0x80+c. COLS cycles.
  - RESTORE: write saved_line to 0x00. 1 cycle, then IDLE.
- Operation sequences:
  - Scroll up: for dst = 0..ROWS-2, with src = dst+1: SEL_SRC, READ, SEL_DST, WRITE(copy). Then SEL_DST row ROWS-1, WRITE(fill).
  - Clear screen: for dst = 0..ROWS-1: SEL_DST, WRITE(fill).
  - Clear line: SEL_DST TARGET, WRITE(fill).
- vid_cs_o is high on every engine cycle. vid_rw_n_o is 0 only in SEL_*, WRITE and RESTORE.
- busy_o rises on the edge that accepts CMD and falls on the edge leaving RESTORE. Busy durations at defaults:
  - scroll: 1+29*162+81+1 = 4781 cycles.
  - clear screen: 1+30*81+1 = 2432 cycles.
  - clear line: 83 cycles.
- A CPU CMD write on the same edge busy falls is ignored; the first accepted write is the one on the following edge.
- Reset: all FSM state, counters and busy_o go to 0; FILL = 0x20, TARGET = 0; buf contents are don't-care. Reset mid-operation aborts immediately with no restore: the video line register keeps its last written value and partially processed rows are not repaired.
- Counters: column counter 7 bits, wraps to 0 at COLS-1; row counter 5 bits. No arithmetic exceeds 8 bits.

Test Plan:
- Fill row r with bytes r*2+c via pass-through; set line = 7; CMD=1 -> busy_o high 4781 cycles; row r holds old row r+1 for r = 0..28; row 29 is all 0x20; video line reg reads 7.
- FILL=0x41, CMD=2 -> busy 2432 cycles; all 2400 cells read 0x41; line reg is restored.
- TARGET=5, FILL=0x2A, CMD=3 -> busy 83 cycles; only row 5 is 0x2A and rows 4 and 6 are unchanged. TARGET=30, CMD=3 -> busy_o stays 0.
- During a scroll, CPU writes 0x55 to video 0x80 and reads it -> write has no effect, read returns 0x00; a second CMD=2 is ignored; STATUS reads 0x01.
- Assert rst_i at cycle 100 of a scroll -> next cycle busy_o=0 and vid_cs_o follows video_cs; FILL reads 0x20; a new CMD=3 then completes in 83 cycles.
- CMD values 0 and 4 -> no busy, no video access.
